// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the device-side PS/2 transmitter.
// Holds the FSM state enum, the frame bit indices and the frame builder.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StGuard
    } state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_STOP_IDX   = 10;
    localparam int unsigned PS2_PARITY_IDX = 9;

    // Bit i of the result is the level driven during frame bit i.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        logic [PS2_FRAME_BITS-1:0] f;
        f                 = '0;
        f[8:1]            = b;
        f[PS2_PARITY_IDX] = ~^b;
        f[PS2_STOP_IDX]   = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/ps2_half_tick.sv
// Half-period timer for the PS/2 clock: counts 0..HALF-1 and pulses tick on HALF-1.
// The count restarts whenever clear is high.
module ps2_half_tick #(
    parameter int unsigned HALF = 1250
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(HALF - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_output_tx.sv
// Device-side PS/2 transmitter: one byte per rts as start, 8 data LSB-first, odd parity, stop.
// Optional PS2OUT_HOLD_EN adds a one-byte hold buffer for requests arriving while busy.
module ps2_output_tx
    import ps2_pkg::*;
#(
    parameter int unsigned HALF = 1250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       rts,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    state_e                    state_q, state_d;
    logic [3:0]                bitn_q, bitn_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      clk_d, data_d, busy_d;
    logic                      tick, clear;
    logic                      start_req;
    logic [7:0]                start_byte;

    // Every phase change lands on a tick, so the timer also restarts across phases.
    assign clear = (state_d != state_q) || (state_q == StIdle);

    ps2_half_tick #(
        .HALF (HALF)
    ) u_half_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

`ifdef PS2OUT_HOLD_EN
    logic [7:0] hold_q, hold_d;
    logic       pend_q, pend_d;

    // A pending byte takes priority over a fresh request once back in idle.
    assign start_req  = rts || pend_q;
    assign start_byte = pend_q ? hold_q : data;

    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        if (state_q != StIdle && rts) begin
            hold_d = data;
            pend_d = 1'b1;
        end else if (state_q == StIdle) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            pend_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
        end
    end
`else
    assign start_req  = rts;
    assign start_byte = data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            bitn_q   <= '0;
            frame_q  <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitn_q   <= bitn_d;
            frame_q  <= frame_d;
            ps2_clk  <= clk_d;
            ps2_data <= data_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bitn_d  = bitn_q;
        frame_d = frame_q;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    frame_d = ps2_frame(start_byte);
                    bitn_d  = '0;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (tick) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (tick) begin
                    if (bitn_q < 4'(PS2_STOP_IDX)) begin
                        bitn_d  = bitn_q + 4'd1;
                        state_d = StHigh;
                    end else begin
                        state_d = StGuard;
                    end
                end
            end
            StGuard: begin
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next output levels; registering them keeps the PS/2 lines glitch-free.
    always_comb begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        busy_d = 1'b0;
        unique case (state_q)
            StIdle: ;
            StHigh: begin
                data_d = frame_q[bitn_q];
                busy_d = 1'b1;
            end
            StLow: begin
                clk_d  = 1'b0;
                data_d = frame_q[bitn_q];
                busy_d = 1'b1;
            end
            StGuard: busy_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ps2_output_tx.sv
// Directed bench for ps2_output_tx with HALF = 8 and a falling-edge PS/2 receiver model.
// Build with PS2OUT_HOLD_EN defined to exercise the hold buffer path.
module tb_ps2_output_tx;

    localparam int unsigned HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       rts;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int          n_checks = 0;
    int          n_err    = 0;
    int          fe_total = 0;
    logic [10:0] rx_sr    = '0;
    int          base;
    int          nb;

    always #5 clk = ~clk;

    ps2_output_tx #(
        .HALF (HALF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .rts      (rts),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy)
    );

    // Host-side receiver: bits arrive LSB-first, so after 11 edges rx_sr[0] is the start bit.
    always @(negedge ps2_clk) begin
        fe_total <= fe_total + 1;
        rx_sr    <= {ps2_data, rx_sr[10:1]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic collect(input string tag, input logic [7:0] b, input logic par,
                           input int edge_base, input bit inject, input logic [7:0] ib);
        int n;
        int cnt;
        int first_low;
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_up"}, busy, 1);
        check({tag, "_start_lvl"}, ps2_data, 0);
        cnt       = 0;
        first_low = -1;
        while (busy === 1'b1 && cnt < 1000) begin
            if (ps2_clk === 1'b0 && first_low < 0) first_low = cnt;
            if (inject && cnt == 50) begin
                data = ib;
                rts  = 1'b1;
            end else if (inject && cnt == 51) begin
                rts = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, cnt, 184);
        check({tag, "_first_fall"}, first_low, HALF);
        check({tag, "_edges"}, fe_total - edge_base, 11);
        check({tag, "_start"}, rx_sr[0], 0);
        check({tag, "_byte"}, rx_sr[8:1], b);
        check({tag, "_parity"}, rx_sr[9], par);
        check({tag, "_stop"}, rx_sr[10], 1);
        check({tag, "_odd"}, ^rx_sr[9:1], 1);
    endtask

    task automatic frame(input string tag, input logic [7:0] b, input logic par,
                         input bit inject, input logic [7:0] ib);
        int eb;
        @(negedge clk);
        eb   = fe_total;
        data = b;
        rts  = 1'b1;
        @(negedge clk);
        rts = 1'b0;
        check({tag, "_lat"}, busy, 0);
        collect(tag, b, par, eb, inject, ib);
    endtask

    initial begin
        reset = 1'b1;
        rts   = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_clk", ps2_clk, 1);
        check("rst_data", ps2_data, 1);
        check("rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("rst_stable", {ps2_clk, ps2_data, busy}, 3'b110);

        frame("b0b", 8'h0B, 1'b0, 1'b0, 8'h00);
        check("b0b_vec", rx_sr, 11'h416);
        repeat (200) @(negedge clk);
        frame("b37", 8'h37, 1'b0, 1'b0, 8'h00);
        frame("b00", 8'h00, 1'b1, 1'b0, 8'h00);
        frame("bff", 8'hFF, 1'b1, 1'b0, 8'h00);

        // Request while busy; data also changes mid-frame without disturbing 0x11.
        frame("b11", 8'h11, 1'b1, 1'b1, 8'hAA);
`ifdef PS2OUT_HOLD_EN
        base = fe_total;
        collect("hold_aa", 8'hAA, 1'b1, base, 1'b0, 8'h00);
`else
        base = fe_total;
        nb   = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
        end
        check("drop_busy", nb, 0);
        check("drop_edges", fe_total - base, 0);
`endif

        @(negedge clk);
        data = 8'h33;
        rts  = 1'b1;
        @(negedge clk);
        rts = 1'b0;
        repeat (70) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_lines", {ps2_clk, ps2_data, busy}, 3'b110);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        frame("b5a", 8'h5A, 1'b1, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_output_tx.md
# ps2_output_tx

Device-side PS/2 transmitter that serialises one byte per request into a standard 11-bit PS/2 frame: start, 8 data LSB-first, odd parity, stop. The block generates both the PS/2 clock and data lines. It sits between a UART receiver and the PS/2 port of a host, acting as a keyboard emulator.

## Interface
- `HALF` (default 1250): PS/2 clock half-period in `clk` cycles. The default gives 10 kHz at 25 MHz. Legal range is 4 or more.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `data`  in  8  byte to send; sampled in the cycle `rts` is seen high while accepted.
- `rts`  in  1  send request; level-sampled on the rising edge of `clk`.
- `ps2_clk`  out  1  PS/2 clock; idles high.
- `ps2_data`  out  1  PS/2 data; idles high.
- `busy`  out  1  high while a frame (including the guard time) is in progress.

## Operation
- **States:** IDLE, HIGH, LOW, GUARD.
  - A bit counter `bitn` runs 0..10 (0 = start, 1-8 = data[0..7], 9 = parity, 10 = stop).
  - A half-period counter runs 0..HALF-1.
- **IDLE:** `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0.
  - When `rts` = 1: latch `data` into the shift register.
  - Compute parity = ~^data, so the 8 data bits plus parity contain an odd number of ones.
  - Set `bitn` = 0 and go to HIGH.
- **HIGH:** `ps2_clk` = 1. `ps2_data` is driven with bit `bitn` from the first cycle of the phase. After HALF cycles, go to LOW.
- **LOW:** `ps2_clk` = 0 and `ps2_data` holds. After HALF cycles:
  - if `bitn` < 10, increment `bitn` and go to HIGH;
  - otherwise go to GUARD.
- **GUARD:** `ps2_clk` = 1, `ps2_data` = 1, `busy` = 1 for HALF cycles, then go to IDLE.
- Data changes only while `ps2_clk` is high. The host samples on each falling edge of `ps2_clk`.
- `rts` is ignored outside IDLE unless the hold buffer is enabled (see Configuration).
- `data` is captured once per frame. Later changes do not affect the frame in flight.
- The block does not support host-to-device transfers, host clock inhibit, or retransmit.

## Timing
- **Reset values:** state IDLE, `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0, counters 0, hold buffer empty.
- **Reset mid-frame:** aborts the frame. Both lines return high in the next cycle.
- **Start latency:** if `rts` is sampled at edge N, then `busy` = 1 and `ps2_data` = 0 after edge N+1. The first `ps2_clk` falling edge comes HALF cycles later.
- **Frame length:** 11 × 2 × HALF cycles with the clock toggling, plus HALF guard cycles. `busy` is high for 23 × HALF cycles in total.
- **Stop bit:** `ps2_data` = 1 through the final low phase.
- **Held `rts`:** if `rts` is still high on returning to IDLE, a new frame starts immediately (back-to-back), with at least HALF cycles of idle high between frames.
- **Output glitches:** outputs are registered, with no glitches. HALF ≥ 4 guarantees that a 3-sample receiver debounce sees every level.

## Configuration
- `PS2OUT_HOLD_EN`
  - **Defined:** a one-byte hold register plus a pending flag is added.
    - `rts` seen while `busy` stores `data` and sets pending; a later `rts` overwrites the stored byte.
    - In GUARD→IDLE with pending set, the stored byte starts the next frame and pending is cleared.
    - `rts` in IDLE with nothing pending behaves as before.
  - **Undefined:** `rts` while `busy` is dropped.

## Structure
- **Shared package `ps2_pkg`:**
  - state enum (IDLE/HIGH/LOW/GUARD);
  - `PS2_FRAME_BITS` = 11, `PS2_STOP_IDX` = 10, `PS2_PARITY_IDX` = 9.
- **Sub-module `ps2_half_tick`:** a HALF-cycle counter.
  - Clears on a phase change.
  - Pulses `tick` for one cycle when the count reaches HALF-1.

## Test plan
- **Reset:** assert `reset` 2 cycles -> `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0 and stable.
- **Byte 0x0B, HALF = 8:** pulse `rts` -> a receiver decoding on falling edges gets start 0, bits 1,1,0,1,0,0,0,0, parity 0, stop 1. Exactly 11 falling edges, and `busy` falls 184 cycles after start.
- **Byte 0x37:** pulse `rts` 250000 cycles later -> decoded 0x37 with parity 0, and no error flag.
- **Byte 0x00:** -> parity 1. Byte 0xFF -> parity 1. Receiver odd-parity check passes in both cases.
- **Busy request:** `rts` pulsed mid-frame with `data` = 0xAA -> without `PS2OUT_HOLD_EN`, nothing is sent after the first frame. With it, 0xAA follows after the guard time.
- **Reset mid-frame:** `reset` asserted during bit 4 -> lines high in the next cycle. A following `rts` with 0x5A gives a clean, correctly decoded frame.
